// File: rtl/mem_access_ctrl_if.sv
// Request/acknowledge data-memory port between the MEM-stage sequencer (master)
// and the data memory (slave).
interface mem_access_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);

    logic                  memReq;
    logic                  memWe;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memWdata;
    logic                  memAck;
    logic [DATA_WIDTH-1:0] memRdata;

    modport master (
        output memReq,
        output memWe,
        output memAddr,
        output memWdata,
        input  memAck,
        input  memRdata
    );

    modport slave (
        input  memReq,
        input  memWe,
        input  memAddr,
        input  memWdata,
        output memAck,
        output memRdata
    );

endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage access sequencer: issues req/ack memory accesses, stalls upstream until each completes
// and owns the MEM/WB register. Define MEM_TIMEOUT_EN to add an ack watchdog with a sticky memError.
module mem_access_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clock,
    input  logic                      reset,

    // EX/MEM side
    input  logic                      memReadInput,
    input  logic                      memWriteInput,
    input  logic [1:0]                wbControlInput,
    input  logic [ADDR_WIDTH-1:0]     addressInput,
    input  logic [DATA_WIDTH-1:0]     writeDataInput,
    input  logic [DATA_WIDTH-1:0]     aluResultInput,
    input  logic [REG_ADDR_WIDTH-1:0] writeRegisterInput,

    // Data memory port
    mem_access_ctrl_if.master         mem,

    output logic                      stall,

    // MEM/WB register
    output logic                      regWrite,
    output logic                      memToReg,
    output logic [DATA_WIDTH-1:0]     readDataMemory,
    output logic [DATA_WIDTH-1:0]     aluResult,
    output logic [REG_ADDR_WIDTH-1:0] writeRegister,

    output logic                      memError
);

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } state_e;

    state_e state_q, state_d;

    logic                      req_q, req_d;
    logic                      we_q, we_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;

    logic                      reg_write_q, reg_write_d;
    logic                      mem_to_reg_q, mem_to_reg_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]     alu_q, alu_d;
    logic [REG_ADDR_WIDTH-1:0] wreg_q, wreg_d;

    logic                      err_q, err_d;
    logic                      op;
    logic                      expire;

    assign op = memReadInput | memWriteInput;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expire = (state_q == StAccess) && !mem.memAck && (cnt_q == CntW'(TIMEOUT_CYCLES));

    // Held at zero in idle so every access starts counting from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (!mem.memAck && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        rdata_d      = rdata_q;
        alu_d        = alu_q;
        wreg_d       = wreg_q;
        err_d        = err_q;
        stall        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (op) begin
                    // Read+write together is a store.
                    stall        = 1'b1;
                    state_d      = StAccess;
                    req_d        = 1'b1;
                    we_d         = memWriteInput;
                    addr_d       = addressInput;
                    wdata_d      = writeDataInput;
                    reg_write_d  = 1'b0;
                    mem_to_reg_d = 1'b0;
                end else begin
                    reg_write_d  = wbControlInput[1];
                    mem_to_reg_d = wbControlInput[0];
                    alu_d        = aluResultInput;
                    wreg_d       = writeRegisterInput;
                end
            end

            StAccess: begin
                if (mem.memAck) begin
                    state_d      = StIdle;
                    req_d        = 1'b0;
                    we_d         = 1'b0;
                    reg_write_d  = wbControlInput[1];
                    mem_to_reg_d = wbControlInput[0];
                    alu_d        = aluResultInput;
                    wreg_d       = writeRegisterInput;
                    if (!we_q) begin
                        rdata_d = mem.memRdata;
                    end
                end else if (expire) begin
                    // Abandon the access: release the pipeline with a bubble and flag it.
                    state_d      = StIdle;
                    req_d        = 1'b0;
                    we_d         = 1'b0;
                    reg_write_d  = 1'b0;
                    mem_to_reg_d = 1'b0;
                    err_d        = 1'b1;
                end else begin
                    stall        = 1'b1;
                    reg_write_d  = 1'b0;
                    mem_to_reg_d = 1'b0;
                end
            end
        endcase

        // Nothing is in flight across a reset edge, so never hold the front end during reset.
        if (reset) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            rdata_q      <= '0;
            alu_q        <= '0;
            wreg_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            rdata_q      <= rdata_d;
            alu_q        <= alu_d;
            wreg_q       <= wreg_d;
            err_q        <= err_d;
        end
    end

    assign mem.memReq     = req_q;
    assign mem.memWe      = we_q;
    assign mem.memAddr    = addr_q;
    assign mem.memWdata   = wdata_q;

    assign regWrite       = reg_write_q;
    assign memToReg       = mem_to_reg_q;
    assign readDataMemory = rdata_q;
    assign aluResult      = alu_q;
    assign writeRegister  = wreg_q;

`ifdef MEM_TIMEOUT_EN
    assign memError       = err_q;
`else
    assign memError       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: stimulus pushes per-cycle expectations into a scoreboard,
// a negedge monitor pops and compares them against the DUT.
module tb_mem_access_ctrl;

    bit clock;
    logic reset;
    logic memReadInput, memWriteInput;
    logic [1:0] wbControlInput;
    logic [31:0] addressInput, writeDataInput, aluResultInput;
    logic [4:0] writeRegisterInput;
    logic stall, regWrite, memToReg, memError;
    logic [31:0] readDataMemory, aluResult;
    logic [4:0] writeRegister;

    mem_access_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) mem_bus ();

    mem_access_ctrl #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .REG_ADDR_WIDTH(5),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .memReadInput      (memReadInput),
        .memWriteInput     (memWriteInput),
        .wbControlInput    (wbControlInput),
        .addressInput      (addressInput),
        .writeDataInput    (writeDataInput),
        .aluResultInput    (aluResultInput),
        .writeRegisterInput(writeRegisterInput),
        .mem               (mem_bus),
        .stall             (stall),
        .regWrite          (regWrite),
        .memToReg          (memToReg),
        .readDataMemory    (readDataMemory),
        .aluResult         (aluResult),
        .writeRegister     (writeRegister),
        .memError          (memError)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          chk;
        logic        stall;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rw;
        logic        m2r;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                cmp("stall", 32'(stall), 32'(e.stall));
                cmp("memReq", 32'(mem_bus.memReq), 32'(e.req));
                cmp("memWe", 32'(mem_bus.memWe), 32'(e.we));
                cmp("memAddr", mem_bus.memAddr, e.addr);
                cmp("memWdata", mem_bus.memWdata, e.wdata);
                cmp("regWrite", 32'(regWrite), 32'(e.rw));
                cmp("memToReg", 32'(memToReg), 32'(e.m2r));
                cmp("readDataMemory", readDataMemory, e.rdata);
                cmp("aluResult", aluResult, e.alu);
                cmp("writeRegister", 32'(writeRegister), 32'(e.wreg));
                cmp("memError", 32'(memError), 32'(e.err));
            end
        end
    end

    task automatic set_in(input logic rd, input logic wr, input logic [1:0] wb,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] alu, input logic [4:0] wreg);
        memReadInput       = rd;
        memWriteInput      = wr;
        wbControlInput     = wb;
        addressInput       = addr;
        writeDataInput     = wdata;
        aluResultInput     = alu;
        writeRegisterInput = wreg;
    endtask

    task automatic set_mem(input logic ack, input logic [31:0] rdata);
        mem_bus.memAck   = ack;
        mem_bus.memRdata = rdata;
    endtask

    task automatic exp_regs(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic rw, input logic m2r,
                            input logic [31:0] rdata, input logic [31:0] alu,
                            input logic [4:0] wreg, input logic err);
        cur.req   = req;
        cur.we    = we;
        cur.addr  = addr;
        cur.wdata = wdata;
        cur.rw    = rw;
        cur.m2r   = m2r;
        cur.rdata = rdata;
        cur.alu   = alu;
        cur.wreg  = wreg;
        cur.err   = err;
    endtask

    // Push this cycle's expectation, then advance to just after the next rising edge.
    task automatic step(input bit chk, input logic stall_exp);
        exp_t t;
        t       = cur;
        t.chk   = chk;
        t.stall = stall_exp;
        sb.push_back(t);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 2'b00, 0, 0, 0, 0);
        set_mem(0, 0);
        exp_regs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;

        // Two reset cycles with random inputs
        for (int i = 0; i < 2; i++) begin
            set_in(1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom,
                   $urandom, 5'($urandom));
            set_mem(1'($urandom), $urandom);
            step(i == 1, 1'b0);
        end

        // Non-memory ops pass through with one cycle of latency
        reset = 1'b0;
        set_mem(0, 0);
        set_in(0, 0, 2'b10, 0, 0, 32'h0000_0055, 5'd9);
        step(1, 1'b0);
        set_in(0, 0, 2'b01, 0, 0, 32'hA5A5_0001, 5'd17);
        exp_regs(0, 0, 0, 0, 1, 0, 0, 32'h55, 5'd9, 0);
        step(1, 1'b0);

        // Load from 0x100, ack three cycles after memReq rises
        set_in(1, 0, 2'b11, 32'h100, 32'hFFFF_0000, 32'h100, 5'd3);
        exp_regs(0, 0, 0, 0, 0, 1, 0, 32'hA5A5_0001, 5'd17, 0);
        step(1, 1'b1);
        exp_regs(1, 0, 32'h100, 32'hFFFF_0000, 0, 0, 0, 32'hA5A5_0001, 5'd17, 0);
        repeat (3) step(1, 1'b1);
        set_mem(1, 32'hDEAD_BEEF);
        step(1, 1'b0);

        // Back-to-back store (read and write both set), ack after one cycle
        set_mem(0, 0);
        set_in(1, 1, 2'b01, 32'h200, 32'h1234_5678, 32'h200, 5'd0);
        exp_regs(0, 0, 32'h100, 32'hFFFF_0000, 1, 1, 32'hDEAD_BEEF, 32'h100, 5'd3, 0);
        step(1, 1'b1);
        exp_regs(1, 1, 32'h200, 32'h1234_5678, 0, 0, 32'hDEAD_BEEF, 32'h100, 5'd3, 0);
        step(1, 1'b1);
        set_mem(1, 32'hBAD0_BAD0);
        step(1, 1'b0);

        // Stray ack while idle must be ignored
        set_mem(1, 32'h1111_1111);
        set_in(0, 0, 2'b10, 0, 0, 32'h77, 5'd5);
        exp_regs(0, 0, 32'h200, 32'h1234_5678, 0, 1, 32'hDEAD_BEEF, 32'h200, 5'd0, 0);
        step(1, 1'b0);

        // Reset in the middle of an access, followed by a late ack
        set_mem(0, 0);
        set_in(1, 0, 2'b11, 32'h300, 0, 32'h300, 5'd7);
        exp_regs(0, 0, 32'h200, 32'h1234_5678, 1, 0, 32'hDEAD_BEEF, 32'h77, 5'd5, 0);
        step(1, 1'b1);
        reset = 1'b1;
        exp_regs(1, 0, 32'h300, 0, 0, 0, 32'hDEAD_BEEF, 32'h77, 5'd5, 0);
        step(1, 1'b0);
        reset = 1'b0;
        set_in(0, 0, 2'b00, 0, 0, 0, 0);
        set_mem(1, 32'hCAFE_F00D);
        exp_regs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1'b0);

        // Load at 0x400 with a long-delayed (or missing) ack
        set_mem(0, 0);
        set_in(1, 0, 2'b11, 32'h400, 0, 32'h400, 5'd12);
        step(1, 1'b1);
        exp_regs(1, 0, 32'h400, 0, 0, 0, 0, 0, 0, 0);
`ifdef MEM_TIMEOUT_EN
        repeat (4) step(1, 1'b1);
        step(1, 1'b0);
        set_in(0, 0, 2'b10, 0, 0, 32'h99, 5'd1);
        exp_regs(0, 0, 32'h400, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1'b0);
        exp_regs(0, 0, 32'h400, 0, 1, 0, 0, 32'h99, 5'd1, 1);
        step(1, 1'b0);
`else
        repeat (7) step(1, 1'b1);
        set_mem(1, 32'h0BAD_F00D);
        step(1, 1'b0);
        set_mem(0, 0);
        set_in(0, 0, 2'b10, 0, 0, 32'h99, 5'd1);
        exp_regs(0, 0, 32'h400, 0, 1, 1, 32'h0BAD_F00D, 32'h400, 5'd12, 0);
        step(1, 1'b0);
        exp_regs(0, 0, 32'h400, 0, 1, 0, 32'h0BAD_F00D, 32'h99, 5'd1, 0);
        step(1, 1'b0);
`endif

        @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage of the 5-stage pipeline over a multi-cycle req/ack memory port.
- Stalls upstream stages until each access completes.
- Owns the MEM/WB pipeline register: inserts a bubble (zero WB controls) while stalled and loads the completed result on ack.
- Sits between the EX/MEM register, the data memory, and the WB mux / register file.

Parameters:
DATA_WIDTH, 32, data bus and ALU result width
ADDR_WIDTH, 32, memory address width
REG_ADDR_WIDTH, 5, destination register index width
TIMEOUT_CYCLES, 16, max cycles waiting for memAck (used only with MEM_TIMEOUT_EN)

Ports:
clock  in  1  single clock, all state on posedge
reset  in  1  synchronous, active-high
memReadInput  in  1  EX/MEM load request
memWriteInput  in  1  EX/MEM store request
wbControlInput  in  2  [1]=regWrite, [0]=memToReg
addressInput  in  ADDR_WIDTH  memory address (ALU result)
writeDataInput  in  DATA_WIDTH  store data
aluResultInput  in  DATA_WIDTH  ALU result forwarded to WB
writeRegisterInput  in  REG_ADDR_WIDTH  destination register
memReq  out  1  registered memory request
memWe  out  1  registered write enable (valid with memReq)
memAddr  out  ADDR_WIDTH  registered address
memWdata  out  DATA_WIDTH  registered store data
memAck  in  1  one-cycle completion pulse from memory
memRdata  in  DATA_WIDTH  load data, valid when memAck=1
stall  out  1  combinational; freezes PC, IF/ID, ID/EX, EX/MEM
regWrite  out  1  MEM/WB
memToReg  out  1  MEM/WB
readDataMemory  out  DATA_WIDTH  MEM/WB
aluResult  out  DATA_WIDTH  MEM/WB
writeRegister  out  REG_ADDR_WIDTH  MEM/WB
memError  out  1  sticky timeout flag (optional feature)

Behaviour:
- Reset (sync, active-high, highest priority): state=IDLE; memReq, memWe, memAddr, memWdata, regWrite, memToReg, readDataMemory, aluResult, writeRegister, memError, timeout counter all 0.
- Definition: op = memReadInput | memWriteInput.
- FSM states: IDLE, ACCESS.
- IDLE, op=0:
  - stall=0.
  - MEM/WB loads the inputs every cycle: regWrite=wbControlInput[1], memToReg=wbControlInput[0], aluResult, writeRegister.
  - readDataMemory holds its value.
  - Pass-through latency: 1 cycle, same as a plain pipeline register.
- IDLE, op=1:
  - stall=1.
  - On the next edge: state goes to ACCESS; memReq=1; memWe=memWriteInput; memAddr and memWdata load from the inputs.
  - MEM/WB loads a bubble: regWrite=0 and memToReg=0; data fields hold.
- ACCESS, memAck=0:
  - stall=1; bubble written to MEM/WB each cycle.
  - memReq, memWe, memAddr, memWdata held stable.
- ACCESS, memAck=1:
  - stall=0 in this cycle.
  - On the edge: MEM/WB loads the full inputs. readDataMemory=memRdata if memWe=0; otherwise readDataMemory holds.
  - memReq=0, memWe=0; state goes to IDLE.
  - A following memory op is detected in IDLE on the next cycle. Minimum access = 2 stall-free-to-stall-free cycles; back-to-back memory ops are separated by one IDLE cycle with memReq=0.
- memReadInput and memWriteInput both 1: treated as a store (memWe=1); the WB controls are passed as given.
- memAck in IDLE: ignored, no state or output change.
- Upstream must hold all inputs stable while stall=1. The block does not re-sample them in ACCESS.
- Reset during ACCESS: return to IDLE with memReq=0 after the edge. A late memAck after reset is ignored.
- Widths: all data paths are straight copies, no arithmetic except the timeout counter.

Optional Feature:
Macro: MEM_TIMEOUT_EN
- Defined:
  - A counter of clog2(TIMEOUT_CYCLES+1) bits clears on entry to ACCESS and increments each ACCESS cycle without memAck.
  - When the count reaches TIMEOUT_CYCLES with memAck=0: stall=0 that cycle. On the edge: MEM/WB loads a bubble (regWrite=0, memToReg=0), memReq=0, state goes to IDLE, memError=1.
  - memError is sticky until reset.
  - memAck in the same cycle as expiry wins as a normal completion; memError is not set.
- Not defined: no counter, ACCESS waits indefinitely, memError tied to 0.

Test Plan:
- Reset asserted 2 cycles with random inputs -> all outputs 0, memReq=0, stall=0.
- Non-memory op: wbControlInput=2'b10, aluResultInput=32'h0000_0055, writeRegisterInput=5'd9, op=0 -> stall=0; next edge regWrite=1, memToReg=0, aluResult=0x55, writeRegister=9.
- Load to 0x100, memAck returned 3 cycles after memReq rises with memRdata=0xDEADBEEF, wbControlInput=2'b11 -> stall high 4 cycles; regWrite=0 bubbles during the stall; then regWrite=1, memToReg=1, readDataMemory=0xDEADBEEF.
- Store: addr 0x200, data 0x12345678, ack after 1 cycle -> memWe=1, memAddr=0x200, memWdata=0x12345678 while memReq=1; readDataMemory unchanged; memReq drops after ack.
- Reset mid-ACCESS, then memAck pulse -> memReq=0 after the reset edge; ack ignored; MEM/WB stays at reset values.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, load with no ack -> memReq high 5 cycles then drops; memError=1 and stays 1; bubble written to MEM/WB; stall=0 on the expiry cycle.
